// File: rtl/mips_pkg.sv
// Shared MIPS constants: instruction field slices, NOP encoding and fetch FSM states.
package mips_pkg;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned FUNCT_MSB = 5;

    localparam logic [5:0]  OP_RTYPE  = 6'b000000;
    localparam logic [31:0] INSTR_NOP = 32'h0;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, its PC+4 and a valid flag.
// Priority is reset, flush, load, hold.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] instr_d,
    input  logic [ADDR_W-1:0] pcplus4_d,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pcplus4,
    output logic              instr_valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr       <= DATA_W'(INSTR_NOP);
            pcplus4     <= '0;
            instr_valid <= 1'b0;
        end else if (flush) begin
            // PCPlus4 is left alone; it is meaningless once the slot is invalid
            instr       <= DATA_W'(INSTR_NOP);
            instr_valid <= 1'b0;
        end else if (load) begin
            instr       <= instr_d;
            pcplus4     <= pcplus4_d;
            instr_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, imem req/ready handshake and IF/ID register.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic [DATA_W-1:0] Instr,
    output logic [5:0]        Op,
    output logic [5:0]        Funct,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic              InstrValid
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next_seq;
    logic              complete;
    logic              branch;

    assign pc_next_seq = pc + ADDR_W'(4);
    assign imem_addr   = pc;
    assign imem_req    = rst_n && (state == FETCH) && !(InstrValid && Stall);
    assign complete    = imem_req && imem_ready;
    assign branch      = BranchTaken && (state != BOOT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= ADDR_W'(RESET_PC);
            state <= BOOT;
        end else if (branch) begin
            pc    <= {BranchTarget[ADDR_W-1:2], 2'b00};
            state <= REDIRECT;
        end else begin
            case (state)
                BOOT:     state <= FETCH;
                REDIRECT: state <= FETCH;
                FETCH:    if (complete) pc <= pc_next_seq;
                default:  state <= BOOT;
            endcase
        end
    end

    // Without a completion an unstalled slot is consumed; a stall holds it
    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (complete && !branch),
        .flush       (branch || (!complete && !Stall)),
        .instr_d     (imem_rdata),
        .pcplus4_d   (pc_next_seq),
        .instr       (Instr),
        .pcplus4     (PCPlus4),
        .instr_valid (InstrValid)
    );

    assign Op    = Instr[OP_MSB:OP_LSB];
    assign Funct = Instr[FUNCT_MSB:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory returns its own address unless overridden.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] Instr;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic [31:0] PCPlus4;
    logic        InstrValid;

    logic        ovr_en;
    logic [31:0] ovr_data;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = ovr_en ? ovr_data : imem_addr;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32),
        .DATA_W   (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Instr        (Instr),
        .Op           (Op),
        .Funct        (Funct),
        .PCPlus4      (PCPlus4),
        .InstrValid   (InstrValid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b1; Stall = 1'b0;
        BranchTaken = 1'b0; BranchTarget = '0; ovr_en = 1'b0; ovr_data = '0;
        step(); step();
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_pcp4", PCPlus4, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // release; a branch during BOOT must be ignored
        rst_n = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h200;
        chk("boot_req", 32'(imem_req), 32'd0);
        step();
        BranchTaken = 1'b0;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("seq_instr", Instr, 32'(4 * i));
            chk("seq_pcp4", PCPlus4, 32'(4 * i + 4));
            chk("seq_valid", 32'(InstrValid), 32'd1);
        end

        // load an add, then stall on it for 3 cycles
        ovr_en = 1'b1; ovr_data = 32'h0123_4820;
        step();
        ovr_en = 1'b0;
        chk("add_instr", Instr, 32'h0123_4820);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_req", 32'(imem_req), 32'd0);
            step();
            chk("stall_instr", Instr, 32'h0123_4820);
            chk("stall_op", 32'(Op), 32'h0);
            chk("stall_funct", 32'(Funct), 32'h20);
            chk("stall_addr", imem_addr, 32'h10);
        end
        Stall = 1'b0;
        #1 chk("unstall_req", 32'(imem_req), 32'd1);
        step();
        chk("resume_instr", Instr, 32'h10);
        chk("resume_pcp4", PCPlus4, 32'h14);
        chk("resume_addr", imem_addr, 32'h14);

        // memory not ready for 4 cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, 32'h14);
            chk("wait_valid", 32'(InstrValid), 32'd0);
            chk("wait_instr", Instr, 32'h0);
        end

        // branch coinciding with a completion
        imem_ready = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h0000_0103;
        step();
        BranchTaken = 1'b0;
        chk("br_valid", 32'(InstrValid), 32'd0);
        chk("br_instr", Instr, 32'h0);
        chk("br_addr", imem_addr, 32'h100);
        chk("br_bubble", 32'(imem_req), 32'd0);
        step();
        chk("br_req", 32'(imem_req), 32'd1);
        chk("br_valid2", 32'(InstrValid), 32'd0);
        step();
        chk("br_instr2", Instr, 32'h100);
        chk("br_pcp4", PCPlus4, 32'h104);

        // PC wrap at the top of the address space, via two back-to-back branches
        BranchTaken = 1'b1; BranchTarget = 32'h0000_0500;
        step();
        BranchTarget = 32'hFFFF_FFFE;
        step();
        BranchTaken = 1'b0;
        chk("br2_addr", imem_addr, 32'hFFFF_FFFC);
        chk("br2_bubble", 32'(imem_req), 32'd0);
        step();
        chk("wrap_req", 32'(imem_req), 32'd1);
        step();
        chk("wrap_instr", Instr, 32'hFFFF_FFFC);
        chk("wrap_pcp4", PCPlus4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // reset during an outstanding request with Stall asserted
        imem_ready = 1'b0;
        step();
        Stall = 1'b1;
        #1 chk("out_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0; imem_ready = 1'b1; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        step();
        chk("mrst_valid", 32'(InstrValid), 32'd0);
        chk("mrst_instr", Instr, 32'h0);
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_req", 32'(imem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID register.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Captures the returned word and presents Op/Funct/Instr to the decode-stage control unit, with stall and branch-redirect handling.
- Sits directly upstream of the control unit, feeding its Op and Funct inputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
imem_addr  output  ADDR_W  fetch address; always equals PC register
imem_req  output  1  fetch request
imem_ready  input  1  memory returns imem_rdata this cycle (valid only while imem_req=1)
imem_rdata  input  DATA_W  fetched instruction word
Stall  input  1  decode cannot accept; hold IF/ID contents
BranchTaken  input  1  single-cycle redirect strobe from decode/execute
BranchTarget  input  ADDR_W  redirect address; bits [1:0] ignored (forced 0)
Instr  output  DATA_W  IF/ID instruction
Op  output  6  Instr[31:26], to control unit
Funct  output  6  Instr[5:0], to control unit
PCPlus4  output  ADDR_W  address of Instr + 4
InstrValid  output  1  Instr holds a live instruction

Behaviour:
- Reset is synchronous, active-low. With rst_n=0 at a rising edge: PC<=RESET_PC, Instr<=32'h0 (NOP), PCPlus4<=0, InstrValid<=0, state<=BOOT. During reset, imem_req=0.
- States:
  - BOOT: one cycle, imem_req=0, always goes to FETCH.
  - FETCH: normal fetching.
  - REDIRECT: one bubble cycle after a branch, imem_req=0, then goes to FETCH.
- imem_req = (state==FETCH) && !(InstrValid && Stall). The request may drop before imem_ready; memory reads are side-effect free.
- Completion is a rising edge with imem_req=1 and imem_ready=1. On completion: Instr<=imem_rdata, PCPlus4<=PC+4, PC<=PC+4, InstrValid<=1. Back-to-back completions give 1 instruction/cycle.
- With no completion and no branch:
  - InstrValid && !Stall: InstrValid<=0 and Instr<=0 (slot consumed).
  - Stall: Instr, PCPlus4 and InstrValid are held.
- BranchTaken=1 at an edge, in state FETCH or REDIRECT (highest priority, overrides Stall and completion):
  - PC<={BranchTarget[31:2],2'b00}.
  - InstrValid<=0 and Instr<=0 (flush).
  - A coinciding imem_ready result is discarded.
  - state<=REDIRECT. A second BranchTaken while in REDIRECT reloads PC and stays REDIRECT one more cycle.
- BranchTaken in BOOT is ignored.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC+4 = 0, with no flag.
- Op and Funct are combinational slices of the Instr register. With InstrValid=0 they read 0, which is NOP sll $0, harmless.
- rst_n low mid-transaction: the outstanding request is abandoned and imem_req drops in the same cycle as the reset edge. No completion is recorded.
- Latency: first imem_req=1 arrives 2 cycles after rst_n rises (BOOT then FETCH). InstrValid follows 1 cycle after the first completion.

Decomposition:
- Shared package mips_pkg contains:
  - Field slices OP_MSB=31, OP_LSB=26, FUNCT_MSB=5.
  - OP_RTYPE=6'b000000.
  - INSTR_NOP=32'h0.
  - Fetch state encoding: BOOT=2'd0, FETCH=2'd1, REDIRECT=2'd2.
- One sub-module, if_id_reg: the Instr/PCPlus4/InstrValid register with load, hold and flush controls. The PC, FSM and handshake logic stay in fetch_stage.

Test Plan:
- Reset with imem_ready tied 1, memory word at addr N = N -> imem_req first high 2 cycles after release at addr 0; then Instr=0,4,8 on consecutive cycles; PCPlus4=4,8,12.
- Stall=1 for 3 cycles while Instr=32'h0123_4820 (add) -> Instr, Op=0, Funct=6'h20 held; imem_req=0 for those 3 cycles; PC unchanged; fetch resumes the cycle after Stall drops.
- imem_ready held 0 for 4 cycles -> imem_req stays 1 with imem_addr stable; InstrValid=0 after the previous instruction is consumed; no PC change.
- BranchTaken with BranchTarget=32'h0000_0103 in the same cycle as imem_ready -> returned word discarded; InstrValid=0; PC=32'h100; one cycle with imem_req=0; next request at 32'h100.
- PC at 32'hFFFF_FFFC with completion -> PCPlus4=0; next imem_addr=0.
- rst_n asserted low during an outstanding request with Stall=1 -> next cycle InstrValid=0, Instr=0, PC=RESET_PC, imem_req=0.
